// File: rtl/mmio_bus_arbiter_pkg.sv
// Shared MMIO definitions: arbiter state encoding, timeout data default and
// device address map used by the bus decoders.
package mmio_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } mmio_state_t;

   localparam logic [31:0] MMIO_TIMEOUT_DATA = 32'hDEAD_BEEF;

   // Device address map (word-aligned registers in the top 64 KiB)
   localparam logic [31:0] MMIO_SW_ADDR   = 32'hFFFF_0000;
   localparam logic [31:0] MMIO_LED_ADDR  = 32'hFFFF_0010;
   localparam logic [31:0] MMIO_SEG7_ADDR = 32'hFFFF_0020;
   localparam logic [31:0] MMIO_BTN_ADDR  = 32'hFFFF_0030;
   localparam logic [31:0] MMIO_UART_ADDR = 32'hFFFF_0080;
   localparam logic [31:0] MMIO_ROM_BASE  = 32'h0000_0000;
   localparam logic [31:0] MMIO_ROM_LAST  = 32'h0000_3FFF;

   function automatic logic mmio_is_io(input logic [31:0] addr);
      return addr[31:16] == 16'hFFFF;
   endfunction

endpackage

// File: rtl/mmio_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie, the master that was
// not granted last time wins.
module mmio_rr_pick2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       gnt_valid,
   output logic       gnt_id
);

   always_comb begin
      gnt_valid = |req;
      gnt_id    = (req == 2'b11) ? ~last_grant : req[1];
   end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Two-master MMIO bus arbiter: round-robin grant, one access at a time,
// with a watchdog that force-completes accesses the device never answers.
module mmio_bus_arbiter
   import mmio_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_DATA   = MMIO_TIMEOUT_DATA
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_done,
   output logic [31:0] m0_rdata,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_done,
   output logic [31:0] m1_rdata,
   output logic        mmio_read,
   output logic        mmio_write,
   output logic [31:0] mmio_addr,
   output logic [31:0] mmio_write_data,
   input  logic        mmio_done,
   input  logic [31:0] mmio_read_data,
   output logic        grant_id,
   output logic        busy,
   output logic        timeout_pulse,
   output logic        timeout_err
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   mmio_state_t   state;
   logic          last_grant;
   logic [CW-1:0] wd_cnt;
   logic [1:0]    req;
   logic          gnt_valid;
   logic          gnt_id;
   logic          gnt_write;
   logic [31:0]   done_data;

   assign req = {m1_read | m1_write, m0_read | m0_write};

   mmio_rr_pick2 u_pick (
      .req        (req),
      .last_grant (last_grant),
      .gnt_valid  (gnt_valid),
      .gnt_id     (gnt_id)
   );

   // read+write together is treated as a write
   assign gnt_write = gnt_id ? m1_write : m0_write;
   assign done_data = mmio_done ? mmio_read_data : TIMEOUT_DATA;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         last_grant      <= 1'b1;
         wd_cnt          <= '0;
         grant_id        <= 1'b0;
         busy            <= 1'b0;
         mmio_read       <= 1'b0;
         mmio_write      <= 1'b0;
         mmio_addr       <= '0;
         mmio_write_data <= '0;
         m0_done         <= 1'b0;
         m1_done         <= 1'b0;
         m0_rdata        <= '0;
         m1_rdata        <= '0;
         timeout_pulse   <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         m0_done       <= 1'b0;
         m1_done       <= 1'b0;
         timeout_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (gnt_valid) begin
                  grant_id        <= gnt_id;
                  last_grant      <= gnt_id;
                  wd_cnt          <= '0;
                  busy            <= 1'b1;
                  mmio_write      <= gnt_write;
                  mmio_read       <= ~gnt_write;
                  mmio_addr       <= gnt_id ? m1_addr : m0_addr;
                  mmio_write_data <= gnt_id ? m1_wdata : m0_wdata;
                  state           <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // device completion takes priority over an expiring watchdog
               if (mmio_done || wd_cnt == CNT_LAST) begin
                  mmio_read  <= 1'b0;
                  mmio_write <= 1'b0;
                  if (grant_id) begin
                     m1_done <= 1'b1;
                     if (!mmio_write) m1_rdata <= done_data;
                  end else begin
                     m0_done <= 1'b1;
                     if (!mmio_write) m0_rdata <= done_data;
                  end
                  if (!mmio_done) begin
                     timeout_pulse <= 1'b1;
                     timeout_err   <= 1'b1;
                  end
                  state <= ST_RESP;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Randomized bench: masters, device and a transaction-timeline reference
// model all live here; every cycle's outputs are compared against the model.
module tb_mmio_bus_arbiter;

   localparam int unsigned T     = 8;
   localparam logic [31:0] TDATA = 32'hDEAD_BEEF;
   localparam int unsigned NCYC  = 3000;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_done, m1_done;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mmio_read, mmio_write;
   logic [31:0] mmio_addr, mmio_write_data;
   logic        mmio_done;
   logic [31:0] mmio_read_data;
   logic        grant_id, busy, timeout_pulse, timeout_err;

   always #5 clk = ~clk;

   mmio_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .sys_clk         (clk),
      .rst             (rst),
      .m0_read         (m0_read),
      .m0_write        (m0_write),
      .m0_addr         (m0_addr),
      .m0_wdata        (m0_wdata),
      .m0_done         (m0_done),
      .m0_rdata        (m0_rdata),
      .m1_read         (m1_read),
      .m1_write        (m1_write),
      .m1_addr         (m1_addr),
      .m1_wdata        (m1_wdata),
      .m1_done         (m1_done),
      .m1_rdata        (m1_rdata),
      .mmio_read       (mmio_read),
      .mmio_write      (mmio_write),
      .mmio_addr       (mmio_addr),
      .mmio_write_data (mmio_write_data),
      .mmio_done       (mmio_done),
      .mmio_read_data  (mmio_read_data),
      .grant_id        (grant_id),
      .busy            (busy),
      .timeout_pulse   (timeout_pulse),
      .timeout_err     (timeout_err)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned cyc   = 0;

   // master models: op 0=read, 1=write, 2=read+write (a write)
   bit          act[2];
   bit          granted[2];
   int unsigned op[2];
   logic [31:0] maddr[2];
   logic [31:0] mwdata[2];
   logic [31:0] addr_tab[5];
   int unsigned lat_tab[7];

   // current access timeline: granted in cycle t_g, strobes t_g+1..t_g+t_k,
   // done in t_g+t_k+1; device answers in BUSY cycle t_L (may never answer)
   bit          t_valid;
   int unsigned t_g, t_k, t_L;
   int unsigned t_m;
   bit          t_wr, t_to;
   logic [31:0] t_addr, t_wdata, t_rdata;

   int unsigned free_at;
   int unsigned last_win;
   logic [31:0] exp_rdata[2];
   bit          exp_terr;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_reset_state();
      check_val("rst_busy",  32'(busy), 32'd0);
      check_val("rst_rd",    32'(mmio_read), 32'd0);
      check_val("rst_wr",    32'(mmio_write), 32'd0);
      check_val("rst_addr",  mmio_addr, 32'd0);
      check_val("rst_wdata", mmio_write_data, 32'd0);
      check_val("rst_gid",   32'(grant_id), 32'd0);
      check_val("rst_done0", 32'(m0_done), 32'd0);
      check_val("rst_done1", 32'(m1_done), 32'd0);
      check_val("rst_rd0",   m0_rdata, 32'd0);
      check_val("rst_rd1",   m1_rdata, 32'd0);
      check_val("rst_tp",    32'(timeout_pulse), 32'd0);
      check_val("rst_terr",  32'(timeout_err), 32'd0);
   endtask

   task automatic drive_masters();
      m0_read  = act[0] && op[0] != 1;
      m0_write = act[0] && op[0] != 0;
      m0_addr  = maddr[0];
      m0_wdata = mwdata[0];
      m1_read  = act[1] && op[1] != 1;
      m1_write = act[1] && op[1] != 0;
      m1_addr  = maddr[1];
      m1_wdata = mwdata[1];
   endtask

   task automatic step(input int unsigned c);
      bit in_strobe, is_done, in_busy;
      int unsigned w;
      in_strobe = t_valid && c >= t_g + 1 && c <= t_g + t_k;
      is_done   = t_valid && c == t_g + t_k + 1;
      in_busy   = in_strobe || is_done;
      if (is_done && !t_wr) exp_rdata[t_m] = t_to ? TDATA : t_rdata;
      if (is_done && t_to) exp_terr = 1'b1;

      check_val("busy", 32'(busy), 32'(in_busy));
      check_val("mmio_read", 32'(mmio_read), 32'(in_strobe && !t_wr));
      check_val("mmio_write", 32'(mmio_write), 32'(in_strobe && t_wr));
      if (in_strobe) begin
         check_val("mmio_addr", mmio_addr, t_addr);
         check_val("mmio_wdata", mmio_write_data, t_wdata);
      end
      if (in_busy) check_val("grant_id", 32'(grant_id), 32'(t_m));
      check_val("m0_done", 32'(m0_done), 32'(is_done && t_m == 0));
      check_val("m1_done", 32'(m1_done), 32'(is_done && t_m == 1));
      check_val("timeout_pulse", 32'(timeout_pulse), 32'(is_done && t_to));
      check_val("timeout_err", 32'(timeout_err), 32'(exp_terr));
      check_val("m0_rdata", m0_rdata, exp_rdata[0]);
      check_val("m1_rdata", m1_rdata, exp_rdata[1]);

      // device: answers only in its chosen BUSY cycle, noise elsewhere
      if (in_strobe) begin
         mmio_done      = (c == t_g + t_L);
         mmio_read_data = (c == t_g + t_L) ? t_rdata : $urandom;
      end else begin
         mmio_done      = ($urandom_range(0, 3) == 0);
         mmio_read_data = $urandom;
      end

      if (is_done) begin
         act[t_m]     = 1'b0;
         granted[t_m] = 1'b0;
         t_valid      = 1'b0;
      end
      for (int m = 0; m < 2; m++) begin
         if (act[m] && !granted[m]) begin
            if ($urandom_range(0, 15) == 0) act[m] = 1'b0;
         end else if (!act[m] && $urandom_range(0, 2) == 0) begin
            act[m]    = 1'b1;
            op[m]     = $urandom_range(0, 2);
            maddr[m]  = ($urandom_range(0, 5) == 5) ? $urandom : addr_tab[$urandom_range(0, 4)];
            mwdata[m] = $urandom;
         end
      end

      if ($urandom_range(0, 199) == 0) begin
         rst        = 1'b1;
         t_valid    = 1'b0;
         granted    = '{1'b0, 1'b0};
         free_at    = c + 1;
         last_win   = 1;
         exp_rdata  = '{32'd0, 32'd0};
         exp_terr   = 1'b0;
      end else begin
         rst = 1'b0;
         if (c >= free_at && (act[0] || act[1])) begin
            if (act[0] && act[1]) w = 1 - last_win;
            else                  w = act[1] ? 1 : 0;
            last_win   = w;
            granted[w] = 1'b1;
            t_valid    = 1'b1;
            t_g        = c;
            t_m        = w;
            t_wr       = (op[w] != 0);
            t_addr     = maddr[w];
            t_wdata    = mwdata[w];
            t_rdata    = $urandom;
            t_L        = lat_tab[$urandom_range(0, 6)];
            t_k        = (t_L < T) ? t_L : T;
            t_to       = (t_L > T);
            free_at    = c + t_k + 2;
         end
      end
      drive_masters();
   endtask

   initial begin
      addr_tab = '{32'hFFFF_0000, 32'hFFFF_0080, 32'hFFFF_0010, 32'hFFFF_0030, 32'h1000_0000};
      lat_tab  = '{1, 2, 3, T - 1, T, T + 1, 1000};
      act      = '{1'b0, 1'b0};
      granted  = '{1'b0, 1'b0};
      op       = '{0, 0};
      maddr    = '{32'd0, 32'd0};
      mwdata   = '{32'd0, 32'd0};
      t_valid  = 1'b0;
      t_g = 0; t_k = 0; t_L = 0; t_m = 0;
      t_wr = 1'b0; t_to = 1'b0;
      t_addr = '0; t_wdata = '0; t_rdata = '0;
      free_at   = 0;
      last_win  = 1;
      exp_rdata = '{32'd0, 32'd0};
      exp_terr  = 1'b0;
      rst            = 1'b1;
      mmio_done      = 1'b1;
      mmio_read_data = 32'h1234_5678;
      drive_masters();

      repeat (3) begin
         @(negedge clk);
         check_reset_state();
      end

      for (int unsigned c = 0; c < NCYC; c++) begin
         cyc = c;
         step(c);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
